// File: rtl/csr_exe.sv
// csr_exe -- executes one CSR instruction (csrrw / csrrs / csrrc) at a time.
//
// Flow: IDLE -> READ -> WAIT_CMT -> WRITE -> RESP -> IDLE.
//   IDLE     : accept an instruction and latch its fields; present its read address.
//   READ     : sample the old CSR value and decide the write and illegal conditions.
//   WAIT_CMT : hold until the instruction is non-speculative. A flush returns to
//              IDLE, and flush wins over commit_valid in the same cycle.
//   WRITE    : pulse exactly one write strobe when a legal write is needed.
//   RESP     : offer the writeback until wb_ready. Flush is ignored here because
//              the instruction has already committed.
//
// Optional feature: define CSR_PRIV_CHECK_EN to make an access illegal when the
// CSR privilege field addr[9:8] exceeds the current priv. Without the macro the
// priv input is ignored.
//
// Handshakes: a transfer takes place on a rising CLK edge where valid and ready
// are both high. issue_ready is high only in IDLE. wb_valid is high only in RESP,
// and wb_res/wb_rd/wb_exc hold steady while wb_valid waits for wb_ready.
//
// Ports:
//   CLK, RSTn                      clock, asynchronous active-low reset
//   issue_valid/issue_ready        instruction handshake
//   issue_fun {rc,rs,rw}, issue_addr, issue_op, issue_rd   instruction fields
//   priv                           current privilege level
//   csr_rd_addr / csr_rd_data      registered read address, combinational read data
//   commit_valid, flush            commit and discard controls for the held instruction
//   csr_addr, csr_op, csr_rw/rs/rc write port toward the CSR registers
//   wb_valid/wb_ready, wb_res, wb_rd, wb_exc   writeback channel
//   dbg_state                      current FSM state encoding, for observation
module csr_exe #(
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [2:0]    issue_fun,
  input  logic [11:0]   issue_addr,
  input  logic [DW-1:0] issue_op,
  input  logic [5:0]    issue_rd,
  input  logic [1:0]    priv,
  output logic [11:0]   csr_rd_addr,
  input  logic [DW-1:0] csr_rd_data,
  input  logic          commit_valid,
  input  logic          flush,
  output logic [11:0]   csr_addr,
  output logic [DW-1:0] csr_op,
  output logic          csr_rw,
  output logic          csr_rs,
  output logic          csr_rc,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_res,
  output logic [5:0]    wb_rd,
  output logic          wb_exc,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WAIT_CMT = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Fields of the instruction currently held
  logic [2:0]    h_fun;
  logic [11:0]   h_addr;
  logic [DW-1:0] h_op;
  logic [5:0]    h_rd;
  logic          do_write;  // set in READ: a legal write must be performed

  // Decode of the held instruction, evaluated while in READ
  logic fun_onehot;
  logic wen;
  logic illegal;
  logic priv_fail;

  assign fun_onehot = (h_fun == 3'b001) | (h_fun == 3'b010) | (h_fun == 3'b100);
  // csrrs/csrrc with a zero operand must not write, so a read-only CSR can still
  // be read with them.
  assign wen = h_fun[0] | ((h_fun[1] | h_fun[2]) & (|h_op));

`ifdef CSR_PRIV_CHECK_EN
  assign priv_fail = (h_addr[9:8] > priv);
`else
  logic priv_unused;
  assign priv_unused = ^priv;
  assign priv_fail   = 1'b0;
`endif

  // addr[11:10] == 2'b11 marks a read-only CSR
  assign illegal = ~fun_onehot | ((h_addr[11:10] == 2'b11) & wen) | priv_fail;

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (issue_valid) state_nxt = S_READ;
      S_READ:     state_nxt = flush ? S_IDLE : S_WAIT_CMT;
      S_WAIT_CMT: begin
        if (flush)             state_nxt = S_IDLE;
        else if (commit_valid) state_nxt = S_WRITE;
      end
      S_WRITE:    state_nxt = S_RESP;
      S_RESP:     if (wb_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: strobes exist only in WRITE. Because an illegal function
  // encoding never sets do_write, at most one strobe can be active.
  always_comb begin
    issue_ready = (state == S_IDLE);
    wb_valid    = (state == S_RESP);
    csr_rw      = (state == S_WRITE) & do_write & h_fun[0];
    csr_rs      = (state == S_WRITE) & do_write & h_fun[1];
    csr_rc      = (state == S_WRITE) & do_write & h_fun[2];
  end

  // Holding registers and result
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      h_fun       <= '0;
      h_addr      <= '0;
      h_op        <= '0;
      h_rd        <= '0;
      csr_rd_addr <= 12'h000;
      wb_res      <= '0;
      wb_exc      <= 1'b0;
      do_write    <= 1'b0;
    end else begin
      if (state == S_IDLE && issue_valid) begin
        h_fun       <= issue_fun;
        h_addr      <= issue_addr;
        h_op        <= issue_op;
        h_rd        <= issue_rd;
        csr_rd_addr <= issue_addr;
      end
      if (state == S_READ) begin
        // An illegal access reports zero as its old value
        wb_res   <= illegal ? '0 : csr_rd_data;
        wb_exc   <= illegal;
        do_write <= wen & ~illegal;
      end
    end
  end

  assign csr_addr  = h_addr;
  assign csr_op    = h_op;
  assign wb_rd     = h_rd;
  assign dbg_state = state;

endmodule

// File: doc/csr_exe.md
CSR_EXE -- requirements
Module: csr_exe

Interface
REQ-001 Parameter: DW, 64, CSR data width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RSTn  input  1  asynchronous active-low reset.
REQ-004 issue_valid  input  1  CSR instruction offered.
REQ-005 issue_ready  output  1  block accepts an instruction; high only in IDLE.
REQ-006 issue_fun  input  3  {rc,rs,rw}; legal only if one-hot.
REQ-007 issue_addr  input  12  CSR address.
REQ-008 issue_op  input  DW  source operand (rs1 value or zimm).
REQ-009 issue_rd  input  6  destination register tag.
REQ-010 priv  input  2  current privilege level.
REQ-011 csr_rd_addr  output  12  registered read address to the external CSR read mux.
REQ-012 csr_rd_data  input  DW  combinational read data for csr_rd_addr.
REQ-013 commit_valid  input  1  held instruction is non-speculative.
REQ-014 flush  input  1  discard held instruction.
REQ-015 csr_addr, csr_op  output  12, DW  write address and operand to CSR registers.
REQ-016 csr_rw, csr_rs, csr_rc  output  1 each  single-cycle write strobes, mutually exclusive.
REQ-017 wb_valid, wb_ready  output, input  1, 1  writeback handshake.
REQ-018 wb_res, wb_rd, wb_exc  output  DW, 6, 1  old CSR value, tag, illegal-access flag.

Function
REQ-019 FSM states SHALL be IDLE, READ, WAIT_CMT, WRITE, RESP.
REQ-020 IDLE: on issue_valid, capture fun/addr/op/rd into holding registers, csr_rd_addr <= issue_addr, go READ.
REQ-021 READ: wb_res <= csr_rd_data; compute illegal; go WAIT_CMT; flush here goes IDLE with no write and no writeback.
REQ-022 Write suppression: wen = rw | ((rs|rc) & op!=0).
REQ-023 Illegal = fun not one-hot, or (addr[11:10]==2'b11 & wen).
REQ-024 WAIT_CMT: flush -> IDLE (priority over commit_valid in the same cycle); commit_valid -> WRITE.
REQ-025 WRITE: assert exactly one strobe for one cycle iff wen & !illegal, with csr_addr/csr_op = held values; go RESP.
REQ-026 Strobes SHALL be 0 in every state other than WRITE.
REQ-027 RESP: wb_valid=1, wb_res/wb_rd/wb_exc stable; wb_ready -> IDLE; flush ignored (already committed).
REQ-028 When wb_exc=1, wb_res is 0.
REQ-029 Minimum latency from accept to wb_valid is 3 cycles (READ, WAIT_CMT with commit, WRITE).
REQ-030 Back-to-back: issue_ready rises the cycle after the wb handshake; no overlap of two instructions.

Reset
REQ-031 On RSTn low: state=IDLE; all strobes, wb_valid, wb_exc = 0; wb_res, csr_op, holding registers = 0; csr_addr, csr_rd_addr = 12'h000.
REQ-032 Reset mid-operation SHALL abandon the instruction with no strobe and no writeback.

Configuration
REQ-033 Macro CSR_PRIV_CHECK_EN: when defined, illegal additionally includes addr[9:8] > priv; when undefined, the priv input is ignored.

Verification
REQ-034 csrrw addr=0x340 op=0xAA, csr_rd_data=0x55, commit -> csr_rw pulse with op 0xAA; wb_res=0x55, wb_exc=0.
REQ-035 csrrs addr=0x300 op=0 -> no strobe; wb_res = read value.
REQ-036 csrrw addr=0xC00 (read-only) -> no strobe; wb_exc=1, wb_res=0.
REQ-037 flush and commit_valid asserted together in WAIT_CMT -> IDLE, no strobe, no wb_valid.
REQ-038 wb_ready held low 5 cycles in RESP -> wb_valid and wb_res stable; issue_ready=0 throughout.
REQ-039 With CSR_PRIV_CHECK_EN: priv=0, csrrs addr=0x300 op=1 -> wb_exc=1; without the macro -> csr_rs pulse.
